// File: rtl/alu_seq_exec.sv
// Execute-stage ALU: decodes ALUOp/funct3/funct7/op and runs the op behind valid/ready.
// Shifts iterate one bit per cycle; define RV_MUL_EN to add a shift-add multiplier.
module alu_seq_exec #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       ALUOp,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [6:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [3:0]       ALUControl,
  output logic             busy
);

  localparam int CW = SHAMT_W + 1;

  localparam logic [3:0] C_ADD  = 4'b0000;
  localparam logic [3:0] C_SUB  = 4'b0001;
  localparam logic [3:0] C_AND  = 4'b0010;
  localparam logic [3:0] C_OR   = 4'b0011;
  localparam logic [3:0] C_XOR  = 4'b0100;
  localparam logic [3:0] C_SLT  = 4'b0101;
  localparam logic [3:0] C_SLTU = 4'b0110;
  localparam logic [3:0] C_SLL  = 4'b0111;
  localparam logic [3:0] C_SRL  = 4'b1000;
  localparam logic [3:0] C_SRA  = 4'b1001;
`ifdef RV_MUL_EN
  localparam logic [3:0] C_MUL  = 4'b1010;
`endif

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_SHIFT = 2'b01;
  localparam logic [1:0] S_DONE  = 2'b10;
`ifdef RV_MUL_EN
  localparam logic [1:0] S_MUL   = 2'b11;
`endif

  logic [1:0]         state;
  logic [3:0]         f3_dec;
  logic [3:0]         dec;
  logic [WIDTH-1:0]   alu_y;
  logic [WIDTH-1:0]   work;
  logic [WIDTH-1:0]   shv;
  logic [CW-1:0]      cnt;
  logic [SHAMT_W-1:0] shamt;
  logic               accept;
  logic               is_shift;
  logic               slt;
  logic               unused_bits;

  assign unused_bits = ^{op, funct7};
  assign shamt       = b[SHAMT_W-1:0];
  assign in_ready    = (state == S_IDLE) |
                       ((state == S_DONE) & out_ready);
  assign accept      = in_valid & in_ready;
  assign out_valid   = (state == S_DONE);
`ifdef RV_MUL_EN
  assign busy = (state == S_SHIFT) | (state == S_MUL);
`else
  assign busy = (state == S_SHIFT);
`endif

  always_comb begin
    f3_dec = C_ADD;
    case (funct3)
      3'b000: f3_dec = (op[5] & funct7[5]) ? C_SUB : C_ADD;
      3'b001: f3_dec = C_SLL;
      3'b010: f3_dec = C_SLT;
      3'b011: f3_dec = C_SLTU;
      3'b100: f3_dec = C_XOR;
      3'b101: f3_dec = funct7[5] ? C_SRA : C_SRL;
      3'b110: f3_dec = C_OR;
      default: f3_dec = C_AND;
    endcase
  end

  always_comb begin
    dec = C_ADD;
    unique case (1'b1)
      ALUOp == 2'b10: dec = f3_dec;
      ALUOp == 2'b01: dec = C_SUB;
      default:        dec = C_ADD;
    endcase
`ifdef RV_MUL_EN
    if (ALUOp == 2'b10 && op[5] &&
        funct7 == 7'b0000001 && funct3 == 3'b000)
      dec = C_MUL;
`endif
  end

  assign is_shift = (dec == C_SLL) | (dec == C_SRL) |
                    (dec == C_SRA);
  assign slt      = $signed(a) < $signed(b);

  // shifts only take this path with shamt 0, where result is a
  always_comb begin
    alu_y = '0;
    case (dec)
      C_ADD:  alu_y = a + b;
      C_SUB:  alu_y = a - b;
      C_AND:  alu_y = a & b;
      C_OR:   alu_y = a | b;
      C_XOR:  alu_y = a ^ b;
      C_SLT:  alu_y = {{(WIDTH-1){1'b0}}, slt};
      C_SLTU: alu_y = {{(WIDTH-1){1'b0}}, a < b};
      C_SLL,
      C_SRL,
      C_SRA:  alu_y = a;
      default: alu_y = '0;
    endcase
  end

  always_comb begin
    shv = {work[WIDTH-1], work[WIDTH-1:1]};
    case (ALUControl)
      C_SLL:   shv = {work[WIDTH-2:0], 1'b0};
      C_SRL:   shv = {1'b0, work[WIDTH-1:1]};
      default: shv = {work[WIDTH-1], work[WIDTH-1:1]};
    endcase
  end

`ifdef RV_MUL_EN
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] macc;

  assign macc = work + (mplier[0] ? mcand : '0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      result     <= '0;
      zero       <= 1'b0;
      ALUControl <= C_ADD;
      work       <= '0;
      cnt        <= '0;
`ifdef RV_MUL_EN
      mcand      <= '0;
      mplier     <= '0;
`endif
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            ALUControl <= dec;
            if (is_shift && shamt != '0) begin
              work  <= a;
              cnt   <= CW'(shamt);
              state <= S_SHIFT;
`ifdef RV_MUL_EN
            end else if (dec == C_MUL) begin
              work   <= '0;
              mcand  <= a;
              mplier <= b;
              cnt    <= CW'(WIDTH);
              state  <= S_MUL;
`endif
            end else begin
              result <= alu_y;
              zero   <= (alu_y == '0);
              state  <= S_DONE;
            end
          end else if (state == S_DONE && out_ready) begin
            state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          work <= shv;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            result <= shv;
            zero   <= (shv == '0);
            state  <= S_DONE;
          end
        end
`ifdef RV_MUL_EN
        S_MUL: begin
          work   <= macc;
          mcand  <= {mcand[WIDTH-2:0], 1'b0};
          mplier <= {1'b0, mplier[WIDTH-1:1]};
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            result <= macc;
            zero   <= (macc == '0);
            state  <= S_DONE;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_exec.sv
// Randomised self-checking bench for alu_seq_exec against a behavioural model.
// Honours RV_MUL_EN in the model so one bench covers both builds.
module tb_alu_seq_exec;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  aluop = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [6:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        zero;
  logic [3:0]  ctrl;
  logic        busy;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_seq_exec #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .ALUOp(aluop), .funct3(funct3),
    .funct7(funct7), .op(op),
    .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero),
    .ALUControl(ctrl), .busy(busy)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] m_ctrl(input logic [1:0] ao,
    input logic [2:0] f3, input logic [6:0] f7, input logic [6:0] opc);
    if (ao != 2'b10) return (ao == 2'b01) ? 4'd1 : 4'd0;
`ifdef RV_MUL_EN
    if (opc[5] && f7 == 7'd1 && f3 == 3'd0) return 4'd10;
`endif
    case (f3)
      3'd0: return (opc[5] && f7[5]) ? 4'd1 : 4'd0;
      3'd1: return 4'd7;
      3'd2: return 4'd5;
      3'd3: return 4'd6;
      3'd4: return 4'd4;
      3'd5: return f7[5] ? 4'd9 : 4'd8;
      3'd6: return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  function automatic logic [31:0] m_res(input logic [3:0] c,
    input logic [31:0] x, input logic [31:0] y);
    int sh;
    longint unsigned p;
    sh = y % 32;
    p = longint'(x) * longint'(y);
    case (c)
      4'd0: return x + y;
      4'd1: return x - y;
      4'd2: return x & y;
      4'd3: return x | y;
      4'd4: return x ^ y;
      4'd5: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd6: return (x < y) ? 32'd1 : 32'd0;
      4'd7: return x << sh;
      4'd8: return x >> sh;
      4'd9: return $unsigned($signed(x) >>> sh);
      default: return p[31:0];
    endcase
  endfunction

  function automatic int m_lat(input logic [3:0] c, input logic [31:0] y);
    if (c == 4'd10) return 33;
    if (c >= 4'd7 && c <= 4'd9) return (y % 32) + 1;
    return 1;
  endfunction

  task automatic drive(input logic [1:0] ao, input logic [2:0] f3,
    input logic [6:0] f7, input logic [6:0] opc,
    input logic [31:0] x, input logic [31:0] y);
    aluop = ao; funct3 = f3; funct7 = f7; op = opc; a = x; b = y;
    in_valid = 1'b1;
  endtask

  task automatic scramble();
    in_valid = 1'b0;
    aluop = 2'($urandom); funct3 = 3'($urandom);
    funct7 = 7'($urandom); op = 7'($urandom);
    a = $urandom; b = $urandom;
  endtask

  task automatic run_op(input string tag, input logic [1:0] ao,
    input logic [2:0] f3, input logic [6:0] f7, input logic [6:0] opc,
    input logic [31:0] x, input logic [31:0] y);
    logic [3:0]  ec;
    logic [31:0] er;
    int el;
    int n;
    ec = m_ctrl(ao, f3, f7, opc);
    er = m_res(ec, x, y);
    el = m_lat(ec, y);
    @(negedge clk);
    drive(ao, f3, f7, opc, x, y);
    check({tag, " in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    scramble();
    n = 1;
    if (el > 1) begin
      check({tag, " busy"}, 64'(busy), 64'd1);
      check({tag, " in_ready busy"}, 64'(in_ready), 64'd0);
    end
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'(el));
    check({tag, " result"}, 64'(result), 64'(er));
    check({tag, " zero"}, 64'(zero), 64'(er == 0));
    check({tag, " ctrl"}, 64'(ctrl), 64'(ec));
    @(posedge clk); #1;
    check({tag, " consumed"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int seen;
    repeat (3) @(negedge clk);
    check("rst in_ready", 64'(in_ready), 64'd1);
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst result", 64'(result), 64'd0);
    check("rst zero", 64'(zero), 64'd0);
    check("rst ctrl", 64'(ctrl), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    rst_n = 1'b1;

    run_op("sub", 2'b10, 3'b000, 7'h20, 7'h33, 32'd5, 32'd5);
    run_op("sra", 2'b10, 3'b101, 7'h20, 7'h33, 32'h8000_0000, 32'd4);
    run_op("srl", 2'b10, 3'b101, 7'h00, 7'h33, 32'h8000_0000, 32'd31);
    run_op("sll0", 2'b10, 3'b001, 7'h00, 7'h13, 32'h1234_5678, 32'h20);
    run_op("addi", 2'b10, 3'b000, 7'h20, 7'h13, 32'd9, 32'd4);
    run_op("br", 2'b01, 3'b000, 7'h00, 7'h63, 32'd3, 32'd7);
    run_op("ld", 2'b00, 3'b010, 7'h20, 7'h03, 32'hFFFF_FFFF, 32'd1);
    run_op("rsv", 2'b11, 3'b101, 7'h20, 7'h33, 32'd10, 32'd20);
    run_op("slt", 2'b10, 3'b010, 7'h00, 7'h33, 32'hFFFF_FFFF, 32'd1);
    run_op("mul", 2'b10, 3'b000, 7'h01, 7'h33, 32'd7, 32'hFFFF_FFFF);

    // backpressure then back-to-back accept
    out_ready = 1'b0;
    @(negedge clk);
    drive(2'b10, 3'b011, 7'h00, 7'h33, 32'd1, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    scramble();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp out_valid", 64'(out_valid), 64'd1);
      check("bp result", 64'(result), 64'd1);
      check("bp in_ready", 64'(in_ready), 64'd0);
      check("bp ctrl", 64'(ctrl), 64'd6);
    end
    out_ready = 1'b1;
    drive(2'b10, 3'b111, 7'h00, 7'h33, 32'hF0, 32'h3C);
    #1;
    check("b2b in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    scramble();
    check("b2b out_valid", 64'(out_valid), 64'd1);
    check("b2b result", 64'(result), 64'h30);
    check("b2b ctrl", 64'(ctrl), 64'd2);
    @(posedge clk); #1;
    check("b2b consumed", 64'(out_valid), 64'd0);

    // reset while shifting
    @(negedge clk);
    drive(2'b10, 3'b001, 7'h00, 7'h33, 32'd1, 32'd20);
    @(posedge clk); #1;
    scramble();
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid rst out_valid", 64'(out_valid), 64'd0);
    check("mid rst busy", 64'(busy), 64'd0);
    check("mid rst in_ready", 64'(in_ready), 64'd1);
    check("mid rst result", 64'(result), 64'd0);
    check("mid rst ctrl", 64'(ctrl), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid || busy) seen++;
    end
    check("mid rst idle", 64'(seen), 64'd0);

    for (int k = 0; k < 80; k++) begin
      logic [6:0] f7r;
      logic [6:0] opr;
      case ($urandom_range(3))
        0: f7r = 7'h00;
        1: f7r = 7'h20;
        2: f7r = 7'h01;
        default: f7r = 7'($urandom);
      endcase
      case ($urandom_range(2))
        0: opr = 7'h33;
        1: opr = 7'h13;
        default: opr = 7'($urandom);
      endcase
      run_op("rand", 2'($urandom), 3'($urandom), f7r, opr,
             $urandom, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
